// File: rtl/solar_mon_pkg.sv
// Shared types and defaults for the solar monitor statistics path.
// Temperature-state encodings, sample width and default alarm thresholds.
package solar_mon_pkg;

   localparam int SAMPLE_W = 12;
   localparam int POWER_W  = 2 * SAMPLE_W;
   localparam int DCNT_W   = 4;

   typedef enum logic [1:0] {
      TS_NORMAL = 2'd0,
      TS_WARN   = 2'd1,
      TS_FAULT  = 2'd2
   } temp_state_t;

   localparam int                  DEF_LOG2_N     = 4;
   localparam logic [SAMPLE_W-1:0] DEF_TEMP_WARN  = 12'd2800;
   localparam logic [SAMPLE_W-1:0] DEF_TEMP_FAULT = 12'd3400;
   localparam logic [SAMPLE_W-1:0] DEF_TEMP_HYST  = 12'd100;
   localparam int                  DEF_DEBOUNCE   = 3;

endpackage

// File: rtl/temp_alarm_fsm.sv
// Debounced, hysteretic NORMAL/WARN/FAULT alarm; advances only on accepted samples.
// State and fault update at the edge taking the DEBOUNCE-th qualifying sample; no backpressure.
module temp_alarm_fsm
   import solar_mon_pkg::*;
#(
   parameter logic [SAMPLE_W-1:0] TEMP_WARN  = DEF_TEMP_WARN,
   parameter logic [SAMPLE_W-1:0] TEMP_FAULT = DEF_TEMP_FAULT,
   parameter logic [SAMPLE_W-1:0] TEMP_HYST  = DEF_TEMP_HYST,
   parameter int                  DEBOUNCE   = DEF_DEBOUNCE
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                sample_valid,
   input  logic [SAMPLE_W-1:0] temperature,
   output logic [1:0]          temp_state,
   output logic                fault
);

   localparam logic [SAMPLE_W-1:0] WARN_CLR  = TEMP_WARN - TEMP_HYST;
   localparam logic [SAMPLE_W-1:0] FAULT_CLR = TEMP_FAULT - TEMP_HYST;
   localparam logic [DCNT_W-1:0]   DEB       = DCNT_W'(DEBOUNCE);

   temp_state_t       state;
   logic [DCNT_W-1:0] cnt_hi;
   logic [DCNT_W-1:0] cnt_lo;
   logic [DCNT_W-1:0] hi_inc;
   logic [DCNT_W-1:0] lo_inc;
   logic              ge_warn;
   logic              ge_fault;
   logic              below_warn_clr;
   logic              below_fault_clr;

   assign hi_inc          = cnt_hi + DCNT_W'(1);
   assign lo_inc          = cnt_lo + DCNT_W'(1);
   assign ge_warn         = (temperature >= TEMP_WARN);
   assign ge_fault        = (temperature >= TEMP_FAULT);
   assign below_warn_clr  = (temperature < WARN_CLR);
   assign below_fault_clr = (temperature < FAULT_CLR);
   assign temp_state      = state;

   // cnt_hi counts toward escalation, cnt_lo toward WARN (from NORMAL) or de-escalation.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= TS_NORMAL;
         cnt_hi <= '0;
         cnt_lo <= '0;
         fault  <= 1'b0;
      end else if (sample_valid) begin
         case (state)
            TS_NORMAL: begin
               if (ge_fault && hi_inc == DEB) begin
                  state  <= TS_FAULT;
                  fault  <= 1'b1;
                  cnt_hi <= '0;
                  cnt_lo <= '0;
               end else if (ge_warn && lo_inc == DEB) begin
                  state  <= TS_WARN;
                  cnt_hi <= '0;
                  cnt_lo <= '0;
               end else begin
                  cnt_hi <= ge_fault ? hi_inc : '0;
                  cnt_lo <= ge_warn ? lo_inc : '0;
               end
            end
            TS_WARN: begin
               if (ge_fault) begin
                  cnt_lo <= '0;
                  if (hi_inc == DEB) begin
                     state  <= TS_FAULT;
                     fault  <= 1'b1;
                     cnt_hi <= '0;
                  end else begin
                     cnt_hi <= hi_inc;
                  end
               end else if (below_warn_clr) begin
                  cnt_hi <= '0;
                  if (lo_inc == DEB) begin
                     state  <= TS_NORMAL;
                     cnt_lo <= '0;
                  end else begin
                     cnt_lo <= lo_inc;
                  end
               end else begin
                  cnt_hi <= '0;
                  cnt_lo <= '0;
               end
            end
            TS_FAULT: begin
               cnt_hi <= '0;
               if (below_fault_clr) begin
                  if (lo_inc == DEB) begin
                     state  <= TS_WARN;
                     fault  <= 1'b0;
                     cnt_lo <= '0;
                  end else begin
                     cnt_lo <= lo_inc;
                  end
               end else begin
                  cnt_lo <= '0;
               end
            end
            default: begin
               state  <= TS_NORMAL;
               fault  <= 1'b0;
               cnt_hi <= '0;
               cnt_lo <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/solar_window_stats.sv
// Window means of V, I and V*I over 2^LOG2_N samples plus temperature alarm.
// Result registered at the edge taking the last sample; held under backpressure, overwritten with sticky overrun.
module solar_window_stats
   import solar_mon_pkg::*;
#(
   parameter int                  LOG2_N     = DEF_LOG2_N,
   parameter logic [SAMPLE_W-1:0] TEMP_WARN  = DEF_TEMP_WARN,
   parameter logic [SAMPLE_W-1:0] TEMP_FAULT = DEF_TEMP_FAULT,
   parameter logic [SAMPLE_W-1:0] TEMP_HYST  = DEF_TEMP_HYST,
   parameter int                  DEBOUNCE   = DEF_DEBOUNCE
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                sample_valid,
   input  logic [SAMPLE_W-1:0] voltage_in,
   input  logic [SAMPLE_W-1:0] current_in,
   input  logic [SAMPLE_W-1:0] temperature_in,
   output logic [SAMPLE_W-1:0] avg_voltage,
   output logic [SAMPLE_W-1:0] avg_current,
   output logic [POWER_W-1:0]  avg_power,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                overrun,
   input  logic                clear_overrun,
   output logic [1:0]          temp_state,
   output logic                fault
);

   localparam int               VACC_W = SAMPLE_W + LOG2_N;
   localparam int               PACC_W = POWER_W + LOG2_N;
   localparam logic [LOG2_N-1:0] LAST  = '1;

   logic [LOG2_N-1:0]  win_cnt;
   logic [VACC_W-1:0]  acc_v;
   logic [VACC_W-1:0]  acc_i;
   logic [PACC_W-1:0]  acc_p;
   logic [VACC_W-1:0]  sum_v;
   logic [VACC_W-1:0]  sum_i;
   logic [PACC_W-1:0]  sum_p;
   logic [POWER_W-1:0] prod;
   logic               win_done;

   assign prod     = voltage_in * current_in;
   assign sum_v    = acc_v + {{LOG2_N{1'b0}}, voltage_in};
   assign sum_i    = acc_i + {{LOG2_N{1'b0}}, current_in};
   assign sum_p    = acc_p + {{LOG2_N{1'b0}}, prod};
   assign win_done = sample_valid && (win_cnt == LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         win_cnt     <= '0;
         acc_v       <= '0;
         acc_i       <= '0;
         acc_p       <= '0;
         avg_voltage <= '0;
         avg_current <= '0;
         avg_power   <= '0;
         out_valid   <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         if (sample_valid) begin
            win_cnt <= win_cnt + LOG2_N'(1);
            acc_v   <= win_done ? '0 : sum_v;
            acc_i   <= win_done ? '0 : sum_i;
            acc_p   <= win_done ? '0 : sum_p;
         end

         // The closing sample is folded in before the shift, so the mean covers all N samples.
         if (win_done) begin
            avg_voltage <= sum_v[VACC_W-1:LOG2_N];
            avg_current <= sum_i[VACC_W-1:LOG2_N];
            avg_power   <= sum_p[PACC_W-1:LOG2_N];
            out_valid   <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         if (win_done && out_valid && !out_ready) begin
            overrun <= 1'b1;
         end else if (clear_overrun) begin
            overrun <= 1'b0;
         end
      end
   end

   temp_alarm_fsm #(
      .TEMP_WARN  (TEMP_WARN),
      .TEMP_FAULT (TEMP_FAULT),
      .TEMP_HYST  (TEMP_HYST),
      .DEBOUNCE   (DEBOUNCE)
   ) u_temp_alarm (
      .clk          (clk),
      .reset        (reset),
      .sample_valid (sample_valid),
      .temperature  (temperature_in),
      .temp_state   (temp_state),
      .fault        (fault)
   );

endmodule

// File: tb/tb_solar_window_stats.sv
// Bench for solar_window_stats: directed scenarios plus random traffic against a queue-based reference model.
module tb_solar_window_stats;

   localparam int N   = 16;
   localparam int DEB = 3;
   localparam int TW  = 2800;
   localparam int TF  = 3400;
   localparam int TH  = 100;

   logic        clk = 1'b0;
   logic        reset;
   logic        sample_valid;
   logic [11:0] voltage_in;
   logic [11:0] current_in;
   logic [11:0] temperature_in;
   logic [11:0] avg_voltage;
   logic [11:0] avg_current;
   logic [23:0] avg_power;
   logic        out_valid;
   logic        out_ready;
   logic        overrun;
   logic        clear_overrun;
   logic [1:0]  temp_state;
   logic        fault;

   solar_window_stats dut (
      .clk            (clk),
      .reset          (reset),
      .sample_valid   (sample_valid),
      .voltage_in     (voltage_in),
      .current_in     (current_in),
      .temperature_in (temperature_in),
      .avg_voltage    (avg_voltage),
      .avg_current    (avg_current),
      .avg_power      (avg_power),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .overrun        (overrun),
      .clear_overrun  (clear_overrun),
      .temp_state     (temp_state),
      .fault          (fault)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   longint      q_v[$];
   longint      q_i[$];
   int          hist[$];
   logic [31:0] e_v, e_i, e_p;
   bit          e_valid, e_ovr;
   int          e_ts;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      q_v.delete();
      q_i.delete();
      hist.delete();
      e_v = 0; e_i = 0; e_p = 0;
      e_valid = 0; e_ovr = 0; e_ts = 0;
   endfunction

   function automatic bit last_all(input bit below, input int thr);
      if (hist.size() < DEB) return 1'b0;
      for (int k = hist.size() - DEB; k < hist.size(); k++) begin
         if (below ? !(hist[k] < thr) : !(hist[k] >= thr)) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic void model_edge(input bit sv, input int v, input int i, input int t,
                                      input bit rdy, input bit clr);
      bit     done = 0;
      longint sv_sum = 0, si_sum = 0, sp_sum = 0;
      int     nts;
      if (sv) begin
         q_v.push_back(v);
         q_i.push_back(i);
         if (q_v.size() == N) begin
            done = 1;
            for (int k = 0; k < N; k++) begin
               sv_sum += q_v[k];
               si_sum += q_i[k];
               sp_sum += q_v[k] * q_i[k];
            end
            q_v.delete();
            q_i.delete();
         end
      end
      if (done && e_valid && !rdy) e_ovr = 1;
      else if (clr)                e_ovr = 0;
      if (done) begin
         e_v = 32'(sv_sum / N);
         e_i = 32'(si_sum / N);
         e_p = 32'(sp_sum / N);
         e_valid = 1;
      end else if (rdy) begin
         e_valid = 0;
      end
      if (sv) begin
         hist.push_back(t);
         nts = e_ts;
         case (e_ts)
            0: if (last_all(0, TF)) nts = 2; else if (last_all(0, TW)) nts = 1;
            1: if (last_all(0, TF)) nts = 2; else if (last_all(1, TW - TH)) nts = 0;
            2: if (last_all(1, TF - TH)) nts = 1;
            default: nts = 0;
         endcase
         if (nts != e_ts) begin
            e_ts = nts;
            hist.delete();
         end
      end
   endfunction

   task automatic compare_all();
      check("avg_voltage", 32'(avg_voltage), e_v);
      check("avg_current", 32'(avg_current), e_i);
      check("avg_power",   32'(avg_power),   e_p);
      check("out_valid",   32'(out_valid),   32'(e_valid));
      check("overrun",     32'(overrun),     32'(e_ovr));
      check("temp_state",  32'(temp_state),  32'(e_ts));
      check("fault",       32'(fault),       32'(e_ts == 2));
   endtask

   // Called at a falling edge; drives, lets one rising edge pass, checks at the next falling edge.
   task automatic cycle(input bit sv, input int v, input int i, input int t,
                        input bit rdy, input bit clr);
      sample_valid   = sv;
      voltage_in     = 12'(v);
      current_in     = 12'(i);
      temperature_in = 12'(t);
      out_ready      = rdy;
      clear_overrun  = clr;
      @(posedge clk);
      model_edge(sv, v, i, t, rdy, clr);
      @(negedge clk);
      compare_all();
   endtask

   task automatic feed(input int n, input int v, input int i, input int t, input bit rdy);
      for (int k = 0; k < n; k++) cycle(1'b1, v, i, t, rdy, 1'b0);
   endtask

   task automatic reset_pulse();
      reset = 1'b0;
      #1;
      model_reset();
      compare_all();
      check("rst_avg_power", 32'(avg_power), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      @(negedge clk);
      reset = 1'b1;
   endtask

   int tcur;

   initial begin
      reset = 1'b0;
      sample_valid = 0; voltage_in = 0; current_in = 0; temperature_in = 0;
      out_ready = 0; clear_overrun = 0;
      model_reset();
      #1;
      compare_all();
      @(negedge clk);
      reset = 1'b1;

      // Constant window
      feed(15, 2000, 1000, 1000, 1'b1);
      check("const_early_valid", 32'(out_valid), 0);
      feed(1, 2000, 1000, 1000, 1'b1);
      check("const_v", 32'(avg_voltage), 2000);
      check("const_i", 32'(avg_current), 1000);
      check("const_p", 32'(avg_power), 2000000);
      check("const_valid", 32'(out_valid), 1);
      check("const_ovr", 32'(overrun), 0);
      cycle(1'b0, 0, 0, 1000, 1'b1, 1'b0);
      check("const_drain", 32'(out_valid), 0);

      // Alternating extremes: truncation
      for (int k = 0; k < N; k++) begin
         if (k % 2 == 0) cycle(1'b1, 4095, 4095, 1000, 1'b1, 1'b0);
         else            cycle(1'b1, 0, 0, 1000, 1'b1, 1'b0);
      end
      check("alt_v", 32'(avg_voltage), 2047);
      check("alt_i", 32'(avg_current), 2047);
      check("alt_p", 32'(avg_power), 8384512);

      // Backpressure across two windows, then overrun clear and set-beats-clear
      feed(N, 100, 10, 1000, 1'b0);
      feed(N, 300, 20, 1000, 1'b0);
      check("ovr_v", 32'(avg_voltage), 300);
      check("ovr_p", 32'(avg_power), 6000);
      check("ovr_set", 32'(overrun), 1);
      cycle(1'b0, 0, 0, 1000, 1'b0, 1'b1);
      check("ovr_clr", 32'(overrun), 0);
      check("ovr_hold_valid", 32'(out_valid), 1);
      feed(N - 1, 50, 5, 1000, 1'b0);
      cycle(1'b1, 50, 5, 1000, 1'b0, 1'b1);
      check("ovr_set_beats_clr", 32'(overrun), 1);
      check("ovr_new_v", 32'(avg_voltage), 50);
      cycle(1'b0, 0, 0, 1000, 1'b1, 1'b1);

      // Temperature walk
      feed(2, 500, 500, 2900, 1'b1);
      feed(1, 500, 500, 2000, 1'b1);
      check("t_glitch_normal", 32'(temp_state), 0);
      feed(3, 500, 500, 2900, 1'b1);
      check("t_warn", 32'(temp_state), 1);
      feed(2, 500, 500, 3500, 1'b1);
      check("t_warn_pending", 32'(temp_state), 1);
      feed(1, 500, 500, 3500, 1'b1);
      check("t_fault", 32'(temp_state), 2);
      check("t_fault_flag", 32'(fault), 1);
      feed(5, 500, 500, 3350, 1'b1);
      check("t_fault_band", 32'(temp_state), 2);
      feed(3, 500, 500, 3200, 1'b1);
      check("t_fault_to_warn", 32'(temp_state), 1);
      check("t_fault_flag_off", 32'(fault), 0);
      feed(3, 500, 500, 2650, 1'b1);
      check("t_normal", 32'(temp_state), 0);
      feed(2, 500, 500, 3500, 1'b1);
      check("t_direct_pending", 32'(temp_state), 0);
      feed(1, 500, 500, 3500, 1'b1);
      check("t_direct_fault", 32'(temp_state), 2);
      feed(3, 500, 500, 3000, 1'b1);
      feed(3, 500, 500, 2000, 1'b1);
      check("t_back_normal", 32'(temp_state), 0);

      // Gapped window
      reset_pulse();
      for (int k = 0; k < 2 * N; k++) begin
         cycle(k % 2 == 0, 2000, 1000, 1000, 1'b1, 1'b0);
         if (k == 2 * N - 2) begin
            check("gap_valid", 32'(out_valid), 1);
            check("gap_p", 32'(avg_power), 2000000);
         end
      end

      // Reset mid-window discards the partial window
      feed(9, 3000, 3000, 1000, 1'b1);
      reset_pulse();
      feed(N - 1, 1000, 200, 1000, 1'b1);
      check("rst_partial_valid", 32'(out_valid), 0);
      feed(1, 1000, 200, 1000, 1'b1);
      check("rst_new_valid", 32'(out_valid), 1);
      check("rst_new_p", 32'(avg_power), 200000);

      // Random traffic
      tcur = 2600;
      for (int k = 0; k < 3000; k++) begin
         tcur += int'($urandom_range(0, 300)) - 150;
         if (tcur < 2400) tcur = 2400;
         if (tcur > 3700) tcur = 3700;
         cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 4095)),
               int'($urandom_range(0, 4095)), tcur,
               (k / 64) % 3 == 2 ? 1'b0 : ($urandom_range(0, 3) != 0),
               $urandom_range(0, 15) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
